// File: rtl/busqueda_sad_param.sv
// Full-search SAD block-matching motion estimator: one motion vector per search into the vector FIFO.
// Optional build macro EARLY_TERMINATION_EN aborts a candidate once its running SAD cannot win.
module busqueda_sad_param #(
    parameter int PIX_W  = 8,
    parameter int BLK    = 16,
    parameter int RANGE  = 7,
    parameter int ADDR_W = 11,
    parameter int MV_W   = 8,
    localparam int SAD_W = PIX_W + 2 * $clog2(BLK)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [MV_W-1:0]         window_limit,
    output logic                    idle,
    output logic                    finish,
    output logic [ADDR_W-1:0]       add_read_img_act,
    input  logic [PIX_W-1:0]        data_rd_img_act,
    output logic [ADDR_W-1:0]       add_read_img_ref,
    input  logic [PIX_W-1:0]        data_rd_img_ref,
    input  logic                    vector_wait_fifo,
    output logic                    vector_wr_req,
    output logic [SAD_W+2*MV_W-1:0] vector_me,
    output logic [2:0]              real_state
);

    localparam int WIN_W = BLK + 2 * RANGE;
    localparam int LB    = $clog2(BLK);
    localparam int CW    = $clog2(2 * RANGE + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEARCH  = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [2*LB-1:0]         pix_q, pix_d;
    logic [CW-1:0]           dx_q, dx_d, dy_q, dy_d, lim_q, lim_d;
    logic [SAD_W-1:0]        sad_q, sad_d, best_sad_q, best_sad_d;
    logic [CW-1:0]           best_dx_q, best_dx_d, best_dy_q, best_dy_d;
    logic                    best_vld_q, best_vld_d;
    logic                    vld_q;
    logic [SAD_W+2*MV_W-1:0] vme_q, vme_d;

    logic [CW-1:0]   lo, hi, lim_new;
    logic [LB-1:0]   row, col;
    logic [PIX_W:0]  diff, mag;
    logic [MV_W-1:0] mv_x, mv_y;

    assign row = pix_q[2*LB-1:LB];
    assign col = pix_q[LB-1:0];
    assign lo  = CW'(RANGE) - lim_q;
    assign hi  = CW'(RANGE) + lim_q;
    assign lim_new = (window_limit > MV_W'(RANGE)) ? CW'(RANGE) : window_limit[CW-1:0];

    assign add_read_img_act = ADDR_W'(pix_q);
    assign add_read_img_ref = (ADDR_W'(dy_q) + ADDR_W'(row)) * ADDR_W'(WIN_W)
                            + ADDR_W'(dx_q) + ADDR_W'(col);

    // Absolute difference in PIX_W+1 bits so the borrow is never lost.
    assign diff = {1'b0, data_rd_img_act} - {1'b0, data_rd_img_ref};
    assign mag  = diff[PIX_W] ? (~diff + 1'b1) : diff;

    assign idle       = (state_q == S_IDLE);
    assign finish     = (state_q == S_DONE);
    assign real_state = state_q;
    assign vector_me  = vme_q;
    // FIFO write: vector_wr_req is a single-cycle strobe, issued only while in WRITE and
    // the FIFO is not signalling full; vector_me is already stable for that whole state.
    assign vector_wr_req = (state_q == S_WRITE) && !vector_wait_fifo;

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        lim_d      = lim_q;
        sad_d      = sad_q;
        best_sad_d = best_sad_q;
        best_dx_d  = best_dx_q;
        best_dy_d  = best_dy_q;
        best_vld_d = best_vld_q;
        vme_d      = vme_q;
        mv_x       = '0;
        mv_y       = '0;

        if (vld_q) sad_d = sad_q + SAD_W'(mag);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lim_d      = lim_new;
                    dx_d       = CW'(RANGE) - lim_new;
                    dy_d       = CW'(RANGE) - lim_new;
                    best_sad_d = '1;
                    best_vld_d = 1'b0;
                    sad_d      = '0;
                    pix_d      = '0;
                    state_d    = S_SEARCH;
                end
            end
            S_SEARCH: begin
                pix_d = pix_q + 1'b1;
                if (pix_q == {2*LB{1'b1}}) state_d = S_DRAIN;
`ifdef EARLY_TERMINATION_EN
                // Running SAD only grows, so this candidate can no longer win.
                if (best_vld_q && (sad_q >= best_sad_q)) begin
                    pix_d   = '0;
                    state_d = S_DRAIN;
                end
`else
`endif
            end
            S_DRAIN: state_d = S_COMPARE;
            S_COMPARE: begin
                if (!best_vld_q || (sad_q < best_sad_q)) begin
                    best_sad_d = sad_q;
                    best_dx_d  = dx_q;
                    best_dy_d  = dy_q;
                    best_vld_d = 1'b1;
                end
                sad_d   = '0;
                state_d = S_SEARCH;
                if (dx_q == hi) begin
                    dx_d = lo;
                    if (dy_q == hi) begin
                        mv_x    = MV_W'(best_dx_d) - MV_W'(RANGE);
                        mv_y    = MV_W'(best_dy_d) - MV_W'(RANGE);
                        vme_d   = {best_sad_d, mv_y, mv_x};
                        state_d = S_WRITE;
                    end else begin
                        dy_d = dy_q + 1'b1;
                    end
                end else begin
                    dx_d = dx_q + 1'b1;
                end
            end
            S_WRITE: if (!vector_wait_fifo) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pix_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            lim_q      <= '0;
            sad_q      <= '0;
            best_sad_q <= '1;
            best_dx_q  <= '0;
            best_dy_q  <= '0;
            best_vld_q <= 1'b0;
            vld_q      <= 1'b0;
            vme_q      <= '0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            lim_q      <= lim_d;
            sad_q      <= sad_d;
            best_sad_q <= best_sad_d;
            best_dx_q  <= best_dx_d;
            best_dy_q  <= best_dy_d;
            best_vld_q <= best_vld_d;
            vld_q      <= (state_q == S_SEARCH);
            vme_q      <= vme_d;
        end
    end

endmodule

// File: tb/tb_busqueda_sad_param.sv
// Randomized bench for busqueda_sad_param against a direct full-search SAD reference model.
module tb_busqueda_sad_param;

    localparam int BLK   = 16;
    localparam int RANGE = 7;
    localparam int WIN   = BLK + 2 * RANGE;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  window_limit;
    logic        idle, finish;
    logic [10:0] add_read_img_act, add_read_img_ref;
    logic [7:0]  data_rd_img_act, data_rd_img_ref;
    logic        vector_wait_fifo;
    logic        vector_wr_req;
    logic [31:0] vector_me;
    logic [2:0]  real_state;

    logic [7:0] act_mem [BLK*BLK];
    logic [7:0] ref_mem [WIN*WIN];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int runs     = 0;
    int addr_err = 0;

    busqueda_sad_param dut (
        .clk(clk), .reset(reset), .start(start), .window_limit(window_limit),
        .idle(idle), .finish(finish),
        .add_read_img_act(add_read_img_act), .data_rd_img_act(data_rd_img_act),
        .add_read_img_ref(add_read_img_ref), .data_rd_img_ref(data_rd_img_ref),
        .vector_wait_fifo(vector_wait_fifo), .vector_wr_req(vector_wr_req),
        .vector_me(vector_me), .real_state(real_state)
    );

    // clock / reset and RAM models (1-cycle read latency)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        data_rd_img_act <= act_mem[add_read_img_act];
        data_rd_img_ref <= ref_mem[add_read_img_ref];
        if (vector_wr_req) wr_cnt++;
    end

    always @(negedge clk)
        if (!reset && (add_read_img_ref > 11'(WIN*WIN-1) || add_read_img_act > 11'(BLK*BLK-1)))
            addr_err++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exhaustive search over the clamped window, strict-less keeps earliest.
    function automatic logic [31:0] model(input int lim);
        int best, bdx, bdy, s, a, b;
        logic [7:0] mvx, mvy;
        best = -1; bdx = 0; bdy = 0;
        for (int dy = RANGE - lim; dy <= RANGE + lim; dy++)
            for (int dx = RANGE - lim; dx <= RANGE + lim; dx++) begin
                s = 0;
                for (int r = 0; r < BLK; r++)
                    for (int c = 0; c < BLK; c++) begin
                        a = int'(act_mem[r*BLK+c]);
                        b = int'(ref_mem[(dy+r)*WIN+dx+c]);
                        s += (a > b) ? a - b : b - a;
                    end
                if (best < 0 || s < best) begin best = s; bdx = dx; bdy = dy; end
            end
        mvx = 8'(bdx - RANGE);
        mvy = 8'(bdy - RANGE);
        return {16'(best), mvy, mvx};
    endfunction

    // Driver: entered on a negedge; runs one search to completion and checks the result.
    task automatic run_search(input string tag, input int wl, input int wait_cyc,
                              input logic [31:0] exp, output logic [31:0] got);
        int lim, n;
        lim = (wl > RANGE) ? RANGE : wl;
        vector_wait_fifo = (wait_cyc > 0);
        window_limit = 8'(wl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (real_state != 3'd4 && n < 70000) begin
            @(negedge clk);
            n++;
        end
        got = vector_me;
        if (n >= 70000) begin
            check({tag, "_timeout"}, 64'(n), 64'(0));
            return;
        end
        runs++;
        // WRITE is entered after 1 start cycle plus 258 cycles per candidate.
        check({tag, "_cycles"}, 64'(n), 64'((2*lim+1)*(2*lim+1)*258 + 1));
        for (int i = 0; i < wait_cyc; i++) begin
            check({tag, "_hold_wr"}, 64'(vector_wr_req), 64'(0));
            check({tag, "_hold_vme"}, 64'(vector_me), 64'(exp));
            @(negedge clk);
        end
        vector_wait_fifo = 1'b0;
        #1;
        check({tag, "_wr_req"}, 64'(vector_wr_req), 64'(1));
        check({tag, "_vme"}, 64'(vector_me), 64'(exp));
        @(negedge clk);
        check({tag, "_finish"}, 64'(finish), 64'(1));
        check({tag, "_wr_once"}, 64'(vector_wr_req), 64'(0));
        @(negedge clk);
        check({tag, "_idle"}, 64'(idle), 64'(1));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp, got;
        reset = 1'b1; start = 1'b0; window_limit = '0; vector_wait_fifo = 1'b0;
        foreach (act_mem[i]) act_mem[i] = '0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 64'(real_state), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_finish", 64'(finish), 64'(0));
        check("rst_wr", 64'(vector_wr_req), 64'(0));
        check("rst_vme", 64'(vector_me), 64'(0));
        check("rst_aa", 64'(add_read_img_act), 64'(0));
        check("rst_ar", 64'(add_read_img_ref), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Exact copy of the block at dx=+2, dy=-1; limit 20 must clamp to 7.
        foreach (ref_mem[i]) ref_mem[i] = 8'($urandom_range(0, 255));
        for (int r = 0; r < BLK; r++)
            for (int c = 0; c < BLK; c++)
                act_mem[r*BLK+c] = ref_mem[(RANGE-1+r)*WIN + RANGE+2+c];
        exp = model(RANGE);
        run_search("match", 20, 0, exp, got);
        check("match_const", 64'(got), 64'({16'd0, 8'hFF, 8'h02}));

        // All zero: every SAD ties, first candidate wins.
        foreach (act_mem[i]) act_mem[i] = '0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        run_search("zeros", 2, 0, model(2), got);
        check("zeros_const", 64'(got), 64'({16'd0, 8'hFE, 8'hFE}));

        // Single candidate with random data.
        foreach (act_mem[i]) act_mem[i] = 8'($urandom_range(0, 255));
        foreach (ref_mem[i]) ref_mem[i] = 8'($urandom_range(0, 255));
        run_search("lim0", 0, 0, model(0), got);
        check("lim0_mv", 64'(got[15:0]), 64'(0));

        // Maximum SAD must not wrap.
        foreach (act_mem[i]) act_mem[i] = 8'hFF;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        run_search("maxsad", 1, 0, model(1), got);
        check("maxsad_const", 64'(got), 64'({16'd65280, 8'hFF, 8'hFF}));

        // Backpressure in WRITE for 5 cycles.
        foreach (act_mem[i]) act_mem[i] = 8'($urandom_range(0, 255));
        foreach (ref_mem[i]) ref_mem[i] = 8'($urandom_range(0, 255));
        run_search("wait", 1, 5, model(1), got);

        // Abort mid-search with reset; a second start during SEARCH is ignored.
        window_limit = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_search", 64'(real_state), 64'(1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored", 64'(real_state), 64'(1));
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_state", 64'(real_state), 64'(0));
        check("abort_idle", 64'(idle), 64'(1));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_wr", 64'(wr_cnt), 64'(runs));
        foreach (act_mem[i]) act_mem[i] = 8'($urandom_range(0, 255));
        foreach (ref_mem[i]) ref_mem[i] = 8'($urandom_range(0, 255));
        run_search("after_rst", 2, 0, model(2), got);

        repeat (3) @(negedge clk);
        check("wr_count", 64'(wr_cnt), 64'(runs));
        check("addr_range", 64'(addr_err), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/busqueda_sad_param.md
Name: busqueda_sad_param

Overview:
Parametrised full-search block-matching motion-estimation engine, the next generation of the busqueda search block. It reads one BLK x BLK current macroblock from the act RAM and a (BLK+2*RANGE)-square search window from the ref RAM. For every candidate offset within a runtime search limit it accumulates the SAD, keeps the best candidate, and pushes one motion vector word into the vector FIFO. It sits between the image-loading logic (which fills both RAMs) and the vector FIFO feeding the ARM host.

Parameters:
PIX_W, 8, pixel width in bits (one pixel per RAM word)
BLK, 16, macroblock edge in pixels (power of 2)
RANGE, 7, maximum search range in pixels; window edge WIN_W = BLK+2*RANGE
ADDR_W, 11, RAM address width; must hold WIN_W*WIN_W
MV_W, 8, signed width of each motion-vector component
SAD_W (localparam), PIX_W+2*clog2(BLK), SAD accumulator width; cannot overflow

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a search when idle
window_limit  in  MV_W  runtime search limit L, unsigned; sampled on start; clamped to RANGE
idle  out  1  high only in IDLE
finish  out  1  one-cycle pulse when the search completes
add_read_img_act  out  ADDR_W  act RAM read address
data_rd_img_act  in  PIX_W  act RAM data, 1-cycle read latency
add_read_img_ref  out  ADDR_W  ref RAM read address
data_rd_img_ref  in  PIX_W  ref RAM data, 1-cycle read latency
vector_wait_fifo  in  1  vector FIFO full / backpressure
vector_wr_req  out  1  one-cycle vector FIFO write strobe
vector_me  out  SAD_W+2*MV_W  {best_sad, mv_y, mv_x}; mv fields are two's complement
real_state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset: state IDLE; idle=1; finish=0; vector_wr_req=0; vector_me=0; both addresses=0; real_state=0. Reset mid-search aborts at once. No FIFO write is issued after reset.
- FSM states: IDLE(0), SEARCH(1), DRAIN(2), COMPARE(3), WRITE(4), DONE(5).
- IDLE -> SEARCH on start. A start pulse in any other state is ignored.
- On start:
  - latch L = min(window_limit, RANGE);
  - set candidate dy = dx = RANGE-L;
  - clear best_sad to all-ones;
  - clear the best-valid flag.
- Address generation:
  - act address = r*BLK + c;
  - ref address = (dy+r)*WIN_W + (dx+c);
  - r and c run over 0..BLK-1, c fastest.
- SEARCH:
  - one address pair is issued per cycle for BLK*BLK cycles;
  - a 1-cycle-delayed valid drives accumulation: sad += |act-ref|, computed unsigned at PIX_W+1 bits.
- DRAIN: 1 cycle; absorbs the last RAM read.
- COMPARE: 1 cycle.
  - If sad < best_sad (strict), or no best exists yet: best_sad = sad, best_dx = dx, best_dy = dy.
  - Ties keep the earlier candidate. Scan order is dy outer, dx inner.
  - Then advance the candidate: dx increments; when dx passes RANGE+L it wraps to RANGE-L and dy increments.
  - If dy passes RANGE+L, go to WRITE; otherwise return to SEARCH with sad cleared.
- Cycle cost: BLK*BLK+2 cycles per candidate; (2L+1)^2 candidates in total.
- WRITE:
  - vector_me = {best_sad, best_dy-RANGE, best_dx-RANGE}; mv fields are sign-extended to MV_W.
  - vector_me stays stable while in WRITE.
  - While vector_wait_fifo=1: hold, vector_wr_req=0.
  - First cycle with vector_wait_fifo=0: vector_wr_req=1 for exactly that cycle, then go to DONE.
- DONE: finish=1 for one cycle, then IDLE. vector_me holds its value until the next start.
- Addresses never exceed WIN_W*WIN_W-1 (ref) or BLK*BLK-1 (act) for any L <= RANGE.

Optional Feature:
EARLY_TERMINATION_EN
- Defined: during SEARCH, once a best exists and the running sad >= best_sad, the current candidate is aborted and goes to DRAIN/COMPARE. The aborted candidate is not taken. Outputs are bit-identical to the undefined build; total cycle count is less than or equal to the undefined build.
- Undefined: every candidate runs all BLK*BLK cycles; cycle count is exactly as stated in Behaviour.

Test Plan:
- Ref window random; act = exact copy of the window block at dx=+2, dy=-1; L=7 -> vector_me = {0, -1, +2}; finish arrives (225*258)+small-constant cycles after start.
- Both RAMs all zero, L=3 -> every SAD is 0; tie rule gives mv = (-3,-3), sad 0.
- window_limit=0 -> a single candidate: mv (0,0), SAD equals the direct sum; start-to-wr_req = 1+256+2+1 cycles. window_limit=20 -> clamped to 7.
- Act all 255, ref all 0 -> sad = 65280 with no wrap; mv = (-7,-7).
- vector_wait_fifo held high for 5 cycles in WRITE -> wr_req stays 0 and vector_me stays stable; wr_req is a single pulse when wait drops; finish follows 1 cycle later.
- Reset asserted mid-SEARCH, then start again with new data -> no wr_req from the aborted run; the second result is correct. A start pulse during SEARCH is ignored.
